// File: rtl/bin_a_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Results saturate to all nines when the input exceeds the digit range.
module bin_a_bcd_seq #(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inicio_in,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ocupado_out,
  output logic                  listo_out,
  output logic                  desborde_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint unsigned MAX_VAL = pow10(DIGITS) - 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state_q, state_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]     work_q, work_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic                 ocupado_q, ocupado_d;
  logic                 listo_q, listo_d;
  logic                 desborde_q, desborde_d;

  logic [BCD_W-1:0]     adj;
  logic [BCD_W-1:0]     shift_work;
  logic [BIN_WIDTH-1:0] shift_bin;

  always_comb begin
    adj = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
    {shift_work, shift_bin} = {adj, bin_q} << 1;
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    ocupado_d  = ocupado_q;
    listo_d    = 1'b0;
    desborde_d = desborde_q;
    case (state_q)
      IDLE: begin
        ocupado_d = 1'b0;
        if (inicio_in) begin
          bin_d     = bin_in;
          work_d    = '0;
          ovf_d     = (64'(bin_in) > MAX_VAL);
          cnt_d     = CNT_W'(BIN_WIDTH);
          ocupado_d = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        work_d = shift_work;
        bin_d  = shift_bin;
        cnt_d  = cnt_q - CNT_W'(1);
        // Last shift: publish the result straight from the shifted value.
        if (cnt_q == CNT_W'(1)) begin
          bcd_d      = ovf_q ? {DIGITS{4'h9}} : shift_work;
          desborde_d = ovf_q;
          listo_d    = 1'b1;
          ocupado_d  = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      work_q     <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      ocupado_q  <= 1'b0;
      listo_q    <= 1'b0;
      desborde_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
      ocupado_q  <= ocupado_d;
      listo_q    <= listo_d;
      desborde_q <= desborde_d;
    end
  end

  assign bcd_out      = bcd_q;
  assign ocupado_out  = ocupado_q;
  assign listo_out    = listo_q;
  assign desborde_out = desborde_q;

endmodule

// File: tb/tb_bin_a_bcd_seq.sv
// Self-checking bench for bin_a_bcd_seq: directed and random conversions
// compared against a decimal-arithmetic reference model.
module tb_bin_a_bcd_seq;

  localparam int BW = 14;
  localparam int DG = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inicio_in;
  logic [BW-1:0] bin_in;
  logic [15:0]   bcd_out;
  logic          ocupado_out;
  logic          listo_out;
  logic          desborde_out;

  int checks = 0;
  int errors = 0;
  logic [15:0] last_bcd = 16'h0;
  logic        last_ovf = 1'b0;

  bin_a_bcd_seq #(.BIN_WIDTH(BW), .DIGITS(DG)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inicio_in    (inicio_in),
    .bin_in       (bin_in),
    .bcd_out      (bcd_out),
    .ocupado_out  (ocupado_out),
    .listo_out    (listo_out),
    .desborde_out (desborde_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_bcd(input int v);
    logic [15:0] r;
    int x;
    if (v > 9999) return 16'h9999;
    r = 16'h0;
    x = v;
    for (int d = 0; d < DG; d++) begin
      r = r | 16'((x % 10) << (4 * d));
      x = x / 10;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // poke: cycle offset at which a stray inicio_in is asserted; rst_at: reset edge offset
  task automatic convert(input int v, input int poke, input int rst_at);
    logic [15:0] exp_bcd;
    logic        exp_ovf;
    exp_bcd = model_bcd(v);
    exp_ovf = (v > 9999);
    inicio_in = 1'b1;
    bin_in    = BW'(v);
    step();
    chk("accept_busy", ocupado_out, 1'b1);
    chk("accept_listo", listo_out, 1'b0);
    chk("accept_bcd_hold", bcd_out, last_bcd);
    inicio_in = 1'b0;
    bin_in    = BW'($urandom_range(0, 16383));
    for (int i = 1; i <= BW; i++) begin
      if (i == poke) begin
        inicio_in = 1'b1;
        bin_in    = BW'(7);
      end
      if (i == rst_at) rst_n = 1'b0;
      step();
      inicio_in = 1'b0;
      bin_in    = BW'($urandom_range(0, 16383));
      if (i == rst_at) begin
        chk("rst_bcd", bcd_out, 16'h0);
        chk("rst_busy", ocupado_out, 1'b0);
        chk("rst_listo", listo_out, 1'b0);
        chk("rst_ovf", desborde_out, 1'b0);
        rst_n    = 1'b1;
        last_bcd = 16'h0;
        last_ovf = 1'b0;
        for (int j = 0; j < BW + 2; j++) begin
          step();
          chk("rst_no_listo", listo_out, 1'b0);
          chk("rst_idle", ocupado_out, 1'b0);
        end
        return;
      end
      if (i < BW) begin
        chk("mid_busy", ocupado_out, 1'b1);
        chk("mid_listo", listo_out, 1'b0);
        chk("mid_bcd_hold", bcd_out, last_bcd);
        chk("mid_ovf_hold", desborde_out, last_ovf);
      end else begin
        chk("done_listo", listo_out, 1'b1);
        chk("done_busy", ocupado_out, 1'b0);
        chk("done_bcd", bcd_out, exp_bcd);
        chk("done_ovf", desborde_out, exp_ovf);
        last_bcd = exp_bcd;
        last_ovf = exp_ovf;
      end
    end
    step();
    chk("after_listo", listo_out, 1'b0);
    chk("after_idle", ocupado_out, 1'b0);
    chk("after_bcd", bcd_out, last_bcd);
  endtask

  initial begin
    rst_n     = 1'b0;
    inicio_in = 1'b0;
    bin_in    = '0;
    step();
    step();
    chk("reset_bcd", bcd_out, 16'h0);
    chk("reset_busy", ocupado_out, 1'b0);
    chk("reset_listo", listo_out, 1'b0);
    chk("reset_ovf", desborde_out, 1'b0);
    rst_n = 1'b1;
    step();

    convert(0, -1, -1);
    convert(1234, -1, -1);
    convert(9999, -1, -1);
    convert(59, -1, -1);
    convert(10000, -1, -1);
    convert(16383, -1, -1);
    convert(42, -1, -1);
    convert(321, 5, -1);
    convert(8765, -1, 6);
    convert(8765, -1, -1);

    // inicio_in held high: one conversion every BW+1 cycles
    inicio_in = 1'b1;
    bin_in    = BW'(500);
    for (int n = 0; n < 3 * (BW + 1); n++) begin
      step();
      chk("held_listo", listo_out, (n % (BW + 1)) == BW);
      chk("held_busy", ocupado_out, (n % (BW + 1)) != BW);
      if ((n % (BW + 1)) == BW) begin
        chk("held_bcd", bcd_out, 16'h0500);
        chk("held_ovf", desborde_out, 1'b0);
      end
    end
    inicio_in = 1'b0;
    last_bcd  = 16'h0500;
    last_ovf  = 1'b0;
    step();
    chk("held_end_idle", ocupado_out, 1'b0);

    for (int r = 0; r < 30; r++) begin
      int v;
      case (r % 5)
        0: v = $urandom_range(9990, 10010);
        default: v = $urandom_range(0, 16383);
      endcase
      convert(v, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin_a_bcd_seq.md
Name: bin_a_bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It takes the chronometer's binary time count and produces packed BCD digits. Each digit feeds a BCD-to-seven-segment display decoder. The handshake is start/busy/done, so the timing core can request a conversion whenever its count changes.

Parameters:
BIN_WIDTH, 14, width of the binary input; also the number of shift cycles per conversion.
DIGITS, 4, number of BCD output digits. Maximum representable value is 10^DIGITS-1 (9999 by default).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  reset, synchronous, active-low.
inicio_in  input  1  conversion request; sampled only in IDLE.
bin_in  input  BIN_WIDTH  unsigned binary value; sampled on the accepting edge only.
bcd_out  output  4*DIGITS  packed BCD result; digit i at [4i+3:4i], digit 0 least significant.
ocupado_out  output  1  high while a conversion is in progress.
listo_out  output  1  one-cycle pulse when bcd_out has just been updated.
desborde_out  output  1  set with each result: 1 if the latched bin_in exceeded 10^DIGITS-1.

Behaviour:
- Reset (rst_n low at a rising edge):
  - bcd_out=0, ocupado_out=0, listo_out=0, desborde_out=0.
  - FSM goes to IDLE; internal shift/working registers cleared.
  - Reset takes priority over everything. A conversion interrupted by reset is abandoned and produces no listo_out pulse.
- FSM states: IDLE, SHIFT.
- IDLE:
  - ocupado_out=0.
  - If inicio_in=1 at edge k:
    - latch bin_in into the binary shift register;
    - clear the BCD working register;
    - compute and latch the overflow flag (bin_in > 10^DIGITS-1);
    - load the iteration counter with BIN_WIDTH;
    - go to SHIFT; ocupado_out=1 from edge k.
- SHIFT, on each edge:
  - every working digit >=5 gets +3 (all digits in parallel);
  - then the {BCD working, binary} concatenation shifts left by 1;
  - the counter decrements.
- Completion: the final (BIN_WIDTH-th) shift happens at edge k+BIN_WIDTH. At that same edge:
  - bcd_out takes the converted value, or all digits 9 if the overflow flag is set (saturation);
  - desborde_out takes the overflow flag;
  - listo_out=1 for exactly one cycle;
  - ocupado_out=0; FSM returns to IDLE.
- Latency: exactly BIN_WIDTH edges from the accepting edge to listo_out (14 by default). Throughput is one conversion per BIN_WIDTH+1 cycles when inicio_in is held high.
- listo_out is low in every other cycle.
- bcd_out and desborde_out hold the last result; they never change mid-conversion. The working register is separate from bcd_out.
- inicio_in while ocupado_out=1 is ignored: not queued, no effect on the in-progress conversion.
- inicio_in high in the cycle listo_out is high: state is IDLE, so it is accepted at that edge (back-to-back operation).
- bin_in changes after the accepting edge have no effect.
- Every output digit is always 0–9; no codes 10–15 ever appear on bcd_out.
- Width rules:
  - working BCD register is 4*DIGITS bits; carries out of the top digit are discarded (overflow handled by saturation);
  - iteration counter is wide enough to hold BIN_WIDTH.

Test Plan:
1. Reset, then inicio_in=1 with bin_in=0 at edge k → ocupado_out=1 from k; listo_out pulse after edge k+14; bcd_out=0x0000, desborde_out=0.
2. bin_in=1234, then bin_in=9999, then bin_in=59 → bcd_out=0x1234, 0x9999, 0x0059 respectively; listo_out high exactly one cycle each; bcd_out stable during the next conversion until its listo_out.
3. bin_in=10000 and bin_in=16383 → bcd_out=0x9999, desborde_out=1; a following conversion of 42 → bcd_out=0x0042, desborde_out=0.
4. inicio_in pulsed at k+5 with bin_in=7 during a conversion of 321 → ignored; result 0x0321 after edge k+14; only one listo_out pulse.
5. rst_n low at edge k+6 of a conversion of 8765 → all outputs 0 from that edge, no listo_out; a new conversion of 8765 after release → 0x8765.
6. inicio_in held high continuously with bin_in=500 → listo_out pulses every 15 cycles; ocupado_out low for exactly one cycle between conversions (the listo cycle); bcd_out=0x0500 each time.
